fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have ports: start  in  1  leave IDLE and begin fetching.
REQ-004 SHALL have ports: mem_ready  in  1  ROM word valid on instr.
REQ-005 SHALL have ports: instr  in  16  ROM data; opcode = instr[15:12], target = instr[5:0].
REQ-006 SHALL have ports: pc_cur  in  6  current program counter value.
REQ-007 SHALL have ports: cond_flag  in  1  ALU condition for conditional branch.
REQ-008 SHALL have ports: pc_inc  out  1  one-cycle pulse: advance PC.
REQ-009 SHALL have ports: branch  out  1  one-cycle pulse: load pc_target into PC.
REQ-010 SHALL have ports: pc_target  out  6  branch destination.
REQ-011 SHALL have ports: ir  out  16  instruction register.
REQ-012 SHALL have ports: alu_en  out  1  execute strobe.
REQ-013 SHALL have ports: wb_en  out  1  register write-back strobe.
REQ-014 SHALL have ports: halted  out  1  sequencer stopped.
REQ-015 SHALL have ports: state  out  3  encoded FSM state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.

Function
REQ-016 SHALL implement FSM: IDLE -> FETCH on start=1; otherwise hold IDLE.
REQ-017 In FETCH: hold while mem_ready=0; on mem_ready=1 load ir<=instr, pulse pc_inc, go to DECODE.
REQ-018 Decode opcodes: 0x0 NOP; 0xD JMP; 0xE BRC (conditional); 0xF HLT; 0xB/0xC per REQ-031..034; all others ALU.
REQ-019 DECODE, NOP -> FETCH; no strobes.
REQ-020 DECODE, JMP -> pulse branch=1, pc_target=ir[5:0]; go to FETCH.
REQ-021 DECODE, BRC with cond_flag=1 -> same as JMP; with cond_flag=0 -> FETCH, no branch.
REQ-022 DECODE, ALU -> EXEC (alu_en=1 one cycle) -> WB (wb_en=1 one cycle) -> FETCH.
REQ-023 DECODE, HLT -> HALT; HALT is absorbing until rst; halted=1 only in HALT.
REQ-024 pc_inc, branch, alu_en, wb_en SHALL be registered and never high simultaneously.
REQ-025 Latency: ALU instruction takes 4 cycles after mem_ready (FETCH..WB); JMP/BRC/NOP take 2 cycles.
REQ-026 start SHALL be ignored outside IDLE; cond_flag SHALL be sampled only in DECODE.
REQ-027 pc_target SHALL hold its last value when branch=0.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, ir=0, pc_target=0, and all strobes and halted=0.
REQ-029 rst asserted mid-instruction SHALL abort it with no further strobes; after release, wait for start.
REQ-030 Reset values SHALL be visible in the same cycle rst rises, without a clock edge.

Configuration
REQ-031 Macro CALL_STACK_EN SHALL compile in a 4-entry, 6-bit return-address stack with a 3-bit depth counter.
REQ-032 With CALL_STACK_EN, CALL (0xC) in DECODE SHALL push pc_cur, then pulse branch with pc_target=ir[5:0].
REQ-033 With CALL_STACK_EN, RET (0xB) SHALL pop the stack and pulse branch with the popped address as pc_target.
REQ-034 With CALL_STACK_EN, a push at depth 4 or a pop at depth 0 SHALL go to HALT with no branch or stack change; stack depth SHALL reset to 0.
REQ-035 Without CALL_STACK_EN, 0xB and 0xC SHALL decode as NOP, and no stack storage SHALL exist.

Verification
REQ-036 Reset, start=1, mem_ready=1, instr=0x1000 -> states 1,2,3,4,1; one pulse each of pc_inc, alu_en, wb_en.
REQ-037 instr=0xD02A -> branch=1 for one cycle with pc_target=0x2A; no alu_en or wb_en.
REQ-038 instr=0xE005 with cond_flag=0 -> no branch; with cond_flag=1 -> branch=1, pc_target=0x05.
REQ-039 mem_ready=0 for 3 cycles in FETCH -> state stays 1 and pc_inc=0; after mem_ready=1, a single pc_inc.
REQ-040 instr=0xF000 -> halted=1 and state=5 held for 10 cycles despite start; rst pulse -> state=0 immediately.
REQ-041 With CALL_STACK_EN: CALL 0x10 at pc_cur=0x03, then RET -> pc_target=0x03; a fifth nested CALL -> HALT.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer: IDLE/FETCH/DECODE/EXEC/WB/HALT with registered strobes.
// Optional return-address stack for CALL/RET when CALL_STACK_EN is defined.
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [15:0] instr,
  input  logic [5:0]  pc_cur,
  input  logic        cond_flag,
  output logic        pc_inc,
  output logic        branch,
  output logic [5:0]  pc_target,
  output logic [15:0] ir,
  output logic        alu_en,
  output logic        wb_en,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_BRC  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t      state_q, state_d;
  logic [15:0] ir_d;
  logic [5:0]  pc_target_d;
  logic        pc_inc_d, branch_d, alu_en_d, wb_en_d;
  logic [3:0]  opcode;

  assign opcode = ir[15:12];

`ifdef CALL_STACK_EN
  logic [5:0] ras [4];
  logic [2:0] depth;
  logic       push, pop;
  logic [5:0] ras_top;

  // Index wraps to 3 at depth 0, but pop is never taken there.
  assign ras_top = ras[depth[1:0] - 2'd1];
`else
  logic pc_cur_unused;
  assign pc_cur_unused = ^pc_cur;
`endif

  always_comb begin
    state_d     = state_q;
    ir_d        = ir;
    pc_target_d = pc_target;
    pc_inc_d    = 1'b0;
    branch_d    = 1'b0;
    alu_en_d    = 1'b0;
    wb_en_d     = 1'b0;
`ifdef CALL_STACK_EN
    push        = 1'b0;
    pop         = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          ir_d     = instr;
          pc_inc_d = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_JMP: begin
            branch_d    = 1'b1;
            pc_target_d = ir[5:0];
          end
          OP_BRC: begin
            if (cond_flag) begin
              branch_d    = 1'b1;
              pc_target_d = ir[5:0];
            end
          end
          OP_HLT: state_d = S_HALT;
`ifdef CALL_STACK_EN
          OP_CALL: begin
            if (depth == 3'd4) begin
              state_d = S_HALT;
            end else begin
              push        = 1'b1;
              branch_d    = 1'b1;
              pc_target_d = ir[5:0];
            end
          end
          OP_RET: begin
            if (depth == 3'd0) begin
              state_d = S_HALT;
            end else begin
              pop         = 1'b1;
              branch_d    = 1'b1;
              pc_target_d = ras_top;
            end
          end
`else
          OP_CALL, OP_RET: ;
`endif
          default: begin
            alu_en_d = 1'b1;
            state_d  = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        wb_en_d = 1'b1;
        state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir        <= '0;
      pc_target <= '0;
      pc_inc    <= 1'b0;
      branch    <= 1'b0;
      alu_en    <= 1'b0;
      wb_en     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir        <= ir_d;
      pc_target <= pc_target_d;
      pc_inc    <= pc_inc_d;
      branch    <= branch_d;
      alu_en    <= alu_en_d;
      wb_en     <= wb_en_d;
    end
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
      for (int unsigned i = 0; i < 4; i++) ras[i] <= '0;
    end else if (push) begin
      ras[depth[1:0]] <= pc_cur;
      depth           <= depth + 3'd1;
    end else if (pop) begin
      depth <= depth - 3'd1;
    end
  end
`endif

  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; stack cases run when CALL_STACK_EN is defined.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready, cond_flag;
  logic [15:0] instr;
  logic [5:0]  pc_cur;
  logic        pc_inc, branch, alu_en, wb_en, halted;
  logic [5:0]  pc_target;
  logic [15:0] ir;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready), .instr(instr),
    .pc_cur(pc_cur), .cond_flag(cond_flag), .pc_inc(pc_inc), .branch(branch),
    .pc_target(pc_target), .ir(ir), .alu_en(alu_en), .wb_en(wb_en),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one ROM word for a single FETCH edge; afterwards the DUT sits in DECODE.
  task automatic fetch(input logic [15:0] w);
    instr     = w;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input logic pi, input logic br,
                               input logic ae, input logic we);
    check({tag, ".pc_inc"}, pc_inc, pi);
    check({tag, ".branch"}, branch, br);
    check({tag, ".alu_en"}, alu_en, ae);
    check({tag, ".wb_en"},  wb_en,  we);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; instr = '0; pc_cur = '0; cond_flag = 1'b0;
    repeat (2) step();
    check("rst.state", state, 0);
    check("rst.ir", ir, 0);
    check("rst.pc_target", pc_target, 0);
    check("rst.halted", halted, 0);
    check_strobes("rst", 0, 0, 0, 0);

    rst = 1'b0;
    step();
    check("idle_hold", state, 0);

    // ALU instruction: states 1,2,3,4,1
    start = 1'b1; mem_ready = 1'b1; instr = 16'h1000;
    step();
    start = 1'b0;
    check("alu.fetch", state, 1);
    check_strobes("alu.fetch", 0, 0, 0, 0);
    step();
    mem_ready = 1'b0;
    check("alu.decode", state, 2);
    check("alu.ir", ir, 16'h1000);
    check_strobes("alu.decode", 1, 0, 0, 0);
    step();
    check("alu.exec", state, 3);
    check_strobes("alu.exec", 0, 0, 1, 0);
    step();
    check("alu.wb", state, 4);
    check_strobes("alu.wb", 0, 0, 0, 1);
    step();
    check("alu.back", state, 1);
    check_strobes("alu.back", 0, 0, 0, 0);

    // JMP 0x2A; start ignored outside IDLE
    start = 1'b1;
    fetch(16'hD02A);
    start = 1'b0;
    check("jmp.decode", state, 2);
    step();
    check("jmp.state", state, 1);
    check("jmp.target", pc_target, 6'h2A);
    check_strobes("jmp", 0, 1, 0, 0);
    step();
    check("jmp.pulse_end", branch, 0);
    check("jmp.target_hold", pc_target, 6'h2A);
    check("jmp.fetch_hold", state, 1);

    // BRC not taken: flag high only during FETCH, low in DECODE
    cond_flag = 1'b1;
    fetch(16'hE005);
    cond_flag = 1'b0;
    step();
    check("brc0.state", state, 1);
    check("brc0.branch", branch, 0);
    check("brc0.target_hold", pc_target, 6'h2A);

    // BRC taken
    fetch(16'hE005);
    cond_flag = 1'b1;
    step();
    cond_flag = 1'b0;
    check("brc1.branch", branch, 1);
    check("brc1.target", pc_target, 6'h05);

    // FETCH stall with mem_ready low, then a NOP
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.state", state, 1);
      check("stall.pc_inc", pc_inc, 0);
    end
    fetch(16'h0000);
    check("nop.decode", state, 2);
    check("nop.pc_inc", pc_inc, 1);
    step();
    check("nop.state", state, 1);
    check_strobes("nop", 0, 0, 0, 0);

`ifdef CALL_STACK_EN
    // CALL 0x10 from 0x03, then RET
    pc_cur = 6'h03;
    fetch(16'hC010);
    step();
    check("call.branch", branch, 1);
    check("call.target", pc_target, 6'h10);
    pc_cur = 6'h11;
    fetch(16'hB000);
    step();
    check("ret.branch", branch, 1);
    check("ret.target", pc_target, 6'h03);
    check("ret.state", state, 1);
    // Four nested calls fill the stack
    for (int i = 0; i < 4; i++) begin
      pc_cur = 6'(6'h20 + i);
      fetch({10'h300, 6'(6'h10 + i)});
      step();
      check("ncall.branch", branch, 1);
      check("ncall.target", pc_target, 6'h10 + i);
    end
    // Fifth call overflows
    fetch(16'hC03F);
    step();
    check("overflow.state", state, 5);
    check("overflow.branch", branch, 0);
    check("overflow.target", pc_target, 6'h13);
    check("overflow.halted", halted, 1);
    #2 rst = 1'b1;
    #1 check("ovf_rst.state", state, 0);
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    // Depth reset to 0: RET underflows to HALT
    fetch(16'hB000);
    step();
    check("underflow.state", state, 5);
    check("underflow.branch", branch, 0);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
`else
    // Without the stack, CALL/RET behave as NOP
    fetch(16'hC03F);
    step();
    check("call_nop.state", state, 1);
    check("call_nop.branch", branch, 0);
    check("call_nop.target", pc_target, 6'h05);
    fetch(16'hB000);
    step();
    check("ret_nop.state", state, 1);
    check_strobes("ret_nop", 0, 0, 0, 0);
`endif

    // HLT is absorbing despite start and mem_ready
    fetch(16'hF000);
    step();
    check("hlt.state", state, 5);
    check("hlt.halted", halted, 1);
    start = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hlt.hold_state", state, 5);
      check("hlt.hold_halted", halted, 1);
    end
    start = 1'b0; mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("hlt_rst.state", state, 0);
    check("hlt_rst.halted", halted, 0);
    check("hlt_rst.ir", ir, 0);
    check("hlt_rst.target", pc_target, 0);
    step();
    rst = 1'b0;

    // Reset mid-instruction aborts with no further strobes
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(16'h2345);
    check("abort.pre_pc_inc", pc_inc, 1);
    #2 rst = 1'b1;
    #1;
    check("abort.state", state, 0);
    check_strobes("abort", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort.idle", state, 0);
      check_strobes("abort.after", 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
